// File: rtl/culsans_sram_arbiter.sv
// culsans_sram_arbiter: round-robin arbiter sharing one single-port SRAM among NumReq requesters
module culsans_sram_arbiter #(
  parameter int unsigned NumReq     = 4,
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned MemLatency = 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NumReq-1:0]                      req_i,
  input  logic [NumReq-1:0]                      we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]       addr_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]     be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]       wdata_i,
  output logic [NumReq-1:0]                      gnt_o,
  output logic [NumReq-1:0]                      rvalid_o,
  output logic [DataWidth-1:0]                   rdata_o,
  output logic                                   mem_req_o,
  output logic                                   mem_we_o,
  output logic [AddrWidth-1:0]                   mem_addr_o,
  output logic [DataWidth/8-1:0]                 mem_be_o,
  output logic [DataWidth-1:0]                   mem_wdata_o,
  input  logic [DataWidth-1:0]                   mem_rdata_i
);
  localparam int unsigned IW = $clog2(NumReq);
  localparam logic [NumReq-1:0] One = {{(NumReq-1){1'b0}}, 1'b1};
  logic [IW-1:0] prio_q, win;
  logic found, grant, rv;
  logic [MemLatency-1:0] v_q, w_q;
  logic [MemLatency-1:0][IW-1:0] id_q;
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      if (!found && req_i[(int'(prio_q) + i) % int'(NumReq)]) begin
        found = 1'b1;
        win = IW'((int'(prio_q) + i) % int'(NumReq));
      end
    end
  end
  assign grant       = found & ~rst_i;
  assign gnt_o       = grant ? One << win : '0;
  assign mem_req_o   = grant;
  assign mem_we_o    = grant & we_i[win];
  assign mem_addr_o  = grant ? addr_i[win] : '0;
  assign mem_be_o    = grant ? be_i[win] : '0;
  assign mem_wdata_o = grant ? wdata_i[win] : '0;
  // in-flight responses are suppressed while reset is held
  assign rv       = v_q[MemLatency-1] & ~rst_i;
  assign rvalid_o = rv ? One << id_q[MemLatency-1] : '0;
  assign rdata_o  = (rv && !w_q[MemLatency-1]) ? mem_rdata_i : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= '0;
      v_q <= '0;
      w_q <= '0;
      id_q <= '0;
    end else begin
      if (grant) prio_q <= (win == IW'(NumReq - 1)) ? '0 : win + 1'b1;
      for (int s = MemLatency - 1; s > 0; s--) begin
        v_q[s] <= v_q[s-1];
        w_q[s] <= w_q[s-1];
        id_q[s] <= id_q[s-1];
      end
      v_q[0] <= grant;
      w_q[0] <= mem_we_o;
      id_q[0] <= win;
    end
  end
  a_gnt_onehot: assert property (@(posedge clk_i) $onehot0(gnt_o));
  a_rv_onehot:  assert property (@(posedge clk_i) $onehot0(rvalid_o));
  a_mem_req:    assert property (@(posedge clk_i) mem_req_o == |gnt_o);
  a_gnt_req:    assert property (@(posedge clk_i) (gnt_o & ~req_i) == '0);
endmodule

// File: tb/tb_culsans_sram_arbiter.sv
// tb_culsans_sram_arbiter: scoreboard bench for the round-robin SRAM arbiter
module tb_culsans_sram_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, mem_req, mem_we;
  logic [3:0] req, we, gnt, rvalid;
  logic [3:0][63:0] addr, wdata;
  logic [3:0][7:0] be;
  logic [63:0] rdata, mem_addr, mem_wdata, rd;
  logic [7:0] mem_be;
  logic [63:0] mem [0:255];
  logic rst3, mem_req3, mem_we3;
  logic [3:0] req3, gnt3, rvalid3;
  logic [3:0][63:0] addr3;
  logic [63:0] rdata3, mem_addr3, mem_wdata3;
  logic [7:0] mem_be3;
  logic [63:0] p3 [0:2];
  int vectors = 0, miscompares = 0, cyc = 0;
  typedef struct {logic [3:0] id; logic [63:0] data; int due;} exp_t;
  exp_t sb[$];
  exp_t e;

  culsans_sram_arbiter #(.NumReq(4), .AddrWidth(64), .DataWidth(64), .MemLatency(1)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(rd));

  culsans_sram_arbiter #(.NumReq(4), .AddrWidth(64), .DataWidth(64), .MemLatency(3)) dut3 (
    .clk_i(clk), .rst_i(rst3), .req_i(req3), .we_i(4'b0), .addr_i(addr3), .be_i('0), .wdata_i('0),
    .gnt_o(gnt3), .rvalid_o(rvalid3), .rdata_o(rdata3), .mem_req_o(mem_req3), .mem_we_o(mem_we3),
    .mem_addr_o(mem_addr3), .mem_be_o(mem_be3), .mem_wdata_o(mem_wdata3), .mem_rdata_i(p3[2]));

  // SRAM models: preloaded on reset; latency-3 model returns address + 0x1000
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 64'h0;
      mem[8'h10] <= 64'hDEAD_BEEF;
      for (int k = 0; k < 4; k++) mem[8'h20 + 8'(k)] <= 64'h100 + 64'(k);
    end else if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 8; b++) if (mem_be[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        rd <= '1;
      end else rd <= mem[mem_addr[7:0]];
    end
    p3[0] <= mem_addr3 + 64'h1000;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rvalid !== 4'b0) begin
      if (sb.size() == 0) chk("rvalid_unexpected", 64'(rvalid), 64'h0);
      else begin
        e = sb.pop_front();
        chk("rvalid_id", 64'(rvalid), 64'(e.id));
        chk("rdata", rdata, e.data);
        chk("resp_cycle", 64'(cyc), 64'(e.due));
      end
    end else chk("rdata_idle", rdata, 64'h0);
  end

  task automatic step(input logic [3:0] r, input logic [3:0] w, input logic [3:0] eg, input logic [63:0] ed);
    int idx;
    req = r;
    we = w;
    @(negedge clk);
    chk("gnt", 64'(gnt), 64'(eg));
    chk("mem_req", 64'(mem_req), 64'(eg != 4'b0));
    idx = 0;
    for (int k = 0; k < 4; k++) if (eg[k]) idx = k;
    chk("mem_addr", mem_addr, (eg != 4'b0) ? addr[idx] : 64'h0);
    chk("mem_we", 64'(mem_we), 64'(|(w & eg)));
    if (eg != 4'b0) sb.push_back('{eg, ed, cyc + 1});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin
      req = 4'hF;
      @(negedge clk);
      chk("rst_gnt", 64'(gnt), 64'h0);
      chk("rst_mem_req", 64'(mem_req), 64'h0);
      chk("rst_mem_addr", mem_addr, 64'h0);
      chk("rst_rvalid", 64'(rvalid), 64'h0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    req = 4'h0;
  endtask

  task automatic step3(input logic [3:0] r, input logic rs, input logic [3:0] eg, input logic [3:0] erv, input logic [63:0] ed);
    req3 = r;
    rst3 = rs;
    @(negedge clk);
    chk("l3_gnt", 64'(gnt3), 64'(eg));
    chk("l3_rvalid", 64'(rvalid3), 64'(erv));
    chk("l3_rdata", rdata3, ed);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; be = '1;
    rst3 = 1'b1; req3 = '0;
    for (int k = 0; k < 4; k++) addr3[k] = 64'h20 + 64'(k);
    do_reset();
    addr[0] = 64'h10;
    step(4'b0001, 4'b0, 4'b0001, 64'hDEAD_BEEF);
    step(4'b0, 4'b0, 4'b0, 64'h0);
    do_reset();
    for (int k = 0; k < 4; k++) addr[k] = 64'h20 + 64'(k);
    for (int i = 0; i < 8; i++) step(4'hF, 4'b0, 4'b0001 << (i % 4), 64'h100 + 64'(i % 4));
    step(4'b0, 4'b0, 4'b0, 64'h0);
    addr[2] = 64'h40; wdata[2] = 64'h1234; be[2] = 8'hFF;
    step(4'b0100, 4'b0100, 4'b0100, 64'h0);
    addr[1] = 64'h40;
    step(4'b0010, 4'b0, 4'b0010, 64'h1234);
    addr[1] = 64'h21; addr[3] = 64'h23;
    step(4'b1000, 4'b0, 4'b1000, 64'h103);
    step(4'b1010, 4'b0, 4'b0010, 64'h101);
    step(4'b1010, 4'b0, 4'b1000, 64'h103);
    step(4'b1010, 4'b0, 4'b0010, 64'h101);
    step(4'b0, 4'b0, 4'b0, 64'h0);
    do_reset();
    addr[0] = 64'h10;
    step(4'b0011, 4'b0, 4'b0001, 64'hDEAD_BEEF);
    step(4'b0, 4'b0, 4'b0, 64'h0);
    step(4'hF, 4'b0, 4'b0010, 64'h101);
    step(4'b0, 4'b0, 4'b0, 64'h0);
    step3(4'hF, 1'b1, 4'b0, 4'b0, 64'h0);
    step3(4'b0001, 1'b0, 4'b0001, 4'b0, 64'h0);
    step3(4'hF, 1'b1, 4'b0, 4'b0, 64'h0);
    step3(4'hF, 1'b1, 4'b0, 4'b0, 64'h0);
    step3(4'hF, 1'b0, 4'b0001, 4'b0, 64'h0);
    step3(4'b0, 1'b0, 4'b0, 4'b0, 64'h0);
    step3(4'b0, 1'b0, 4'b0, 4'b0, 64'h0);
    step3(4'b0, 1'b0, 4'b0, 4'b0001, 64'h1020);
    step3(4'b0, 1'b0, 4'b0, 4'b0, 64'h0);
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/culsans_sram_arbiter.md
# culsans_sram_arbiter

Round-robin arbiter sharing the single-port main SRAM of `culsans_top` among `NumReq` requesters, e.g. per-core memory ports plus the debug/loader port. It sits between the requester-side OBI-style request/response channels and the `tc_sram` macro. It issues at most one memory access per cycle and routes each response back to its originator after the fixed SRAM read latency.

## Interface
- `NumReq`, 4: number of requesters, 2..8.
- `AddrWidth`, 64: word-address width, passed through unchanged.
- `DataWidth`, 64: data width; byte-enable width is `DataWidth/8`.
- `MemLatency`, 1: cycles from `mem_req_o` to valid `mem_rdata_i`, 1..4.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_i` in NumReq: per-requester request.
- `we_i` in NumReq: per-requester write enable.
- `addr_i` in NumReq×AddrWidth: per-requester address.
- `be_i` in NumReq×DataWidth/8: per-requester byte enables.
- `wdata_i` in NumReq×DataWidth: per-requester write data.
- `gnt_o` out NumReq: one-hot-or-zero grant.
- `rvalid_o` out NumReq: one-hot-or-zero response valid.
- `rdata_o` out DataWidth: shared response data; qualified by `rvalid_o`.
- `mem_req_o`, `mem_we_o` out 1: SRAM request and write enable.
- `mem_addr_o` out AddrWidth, `mem_be_o` out DataWidth/8, `mem_wdata_o` out DataWidth: SRAM command.
- `mem_rdata_i` in DataWidth: SRAM read data.

## Operation
- Request rule: a requester holds `req_i` and its command stable until it sees `gnt_o` high. Dropping `req_i` before grant is permitted; the request is then withdrawn.
- Arbitration is combinational on `req_i` and the priority pointer `prio_q` (log2 NumReq bits). The winner is the first asserted requester at or after `prio_q`, scanning upward with wrap from NumReq-1 to 0.
- On a grant to index k, `prio_q` becomes (k+1) mod NumReq at the next edge. With no grant, `prio_q` holds.
- The winner's command is muxed to the `mem_*` outputs and `mem_req_o` is set to 1. With no winner, `mem_req_o` = 0 and `mem_we_o` = 0, and `mem_addr_o`/`mem_be_o`/`mem_wdata_o` are 0.
- Response tracking: a shift register `MemLatency` deep holds {valid, id, we} per stage. Stage 0 is loaded on every grant.
- Every granted access, reads and writes alike, yields exactly one `rvalid_o[id]` pulse `MemLatency` cycles after the grant.
- `rdata_o` = `mem_rdata_i` for reads and 0 for writes. `rdata_o` = 0 whenever no response is valid.
- Back-to-back grants are accepted every cycle; the shift register never stalls. There is no backpressure on responses.
- Reset:
  - While `rst_i` = 1: `gnt_o` = 0, `mem_req_o` = 0, `prio_q` <= 0, all tracking stages cleared.
  - Responses in flight when reset asserts are dropped, with no `rvalid_o` from the first cycle reset is sampled.
- Reset values: `gnt_o` 0, `rvalid_o` 0, `rdata_o` 0, `mem_req_o` 0, `mem_we_o` 0, `mem_addr_o` 0, `mem_be_o` 0, `mem_wdata_o` 0.

## Timing
- Cycle t: `req_i[k]` high and k wins. Then `gnt_o[k]` = 1 and `mem_req_o` = 1 in t (combinational).
- Cycle t+`MemLatency`: `rvalid_o[k]` = 1 and `rdata_o` valid. This is a registered path from the tracking pipe; `mem_rdata_i` is used combinationally.
- Throughput: one grant per cycle.
- Fairness bound: with N continuously requesting, each waits at most NumReq-1 cycles between grants.
- Simultaneous requests: exactly one grant per cycle, and `gnt_o` is always one-hot-or-zero.
- Single requester: granted every cycle it requests, regardless of `prio_q`.
- Pointer wrap: a grant to NumReq-1 sets `prio_q` to 0.
- Assertions:
  - `$onehot0(gnt_o)` and `$onehot0(rvalid_o)`.
  - `mem_req_o` == `|gnt_o`.
  - `gnt_o[k]` implies `req_i[k]`.

## Test plan
- Single read: after reset, req 0 reads addr 0x10 with SRAM preloaded to 0xDEADBEEF; `MemLatency`=1. Required: `gnt_o` = 4'b0001 in t; `rvalid_o` = 4'b0001 and `rdata_o` = 0xDEADBEEF in t+1.
- Full contention: all 4 requesters hold reads for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3; the response order matches, each delayed by `MemLatency`.
- Write-then-read: req 2 writes 0x1234 with `be` = 0xFF to 0x40, then req 1 reads 0x40. Required: `rvalid_o[2]` with `rdata_o` = 0; then `rvalid_o[1]` with `rdata_o` = 0x1234.
- Wrap and skip: grant to 3, then only req 1 and req 3 requesting. Required: the next grant goes to 1, then 3, then 1.
- Reset mid-flight: `MemLatency`=3, grant req 0, assert `rst_i` one cycle later for 2 cycles. Required: no `rvalid_o` ever for that access; `prio_q` = 0 after reset; the next contended grant goes to 0.
- Withdrawn request: req 1 pulses `req_i` for a cycle in which req 0 wins. Required: no grant or response for req 1; `prio_q` = 1.
